decode_prefix_seq: RTL
======================

DECODE_PREFIX_SEQ -- requirements
Module: decode_prefix_seq

Interface
REQ-001 SHALL have parameter WORD_W, 15, instruction and index word width (>=15).
REQ-002 SHALL have parameter MAX_INDEX_DEPTH, 1, maximum number of consecutive INDEX prefixes allowed before a target instruction (1..7).
REQ-003 SHALL have parameter RESET_HOLD, 1, number of cycles after reset during which opcode-0 transfers are suppressed (0..15).
REQ-004 SHALL have a single clock and a synchronous, active-low reset; no other clock or reset SHALL exist.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_l  in  1  synchronous active-low reset.
REQ-007 flush  in  1  discard all pending prefixes and the output entry.
REQ-008 in_valid  in  1  instr/index_data valid.
REQ-009 in_ready  out  1  word accepted when in_valid & in_ready.
REQ-010 instr  in  WORD_W  raw fetched instruction; opcode = bits[14:12], address = bits[11:0].
REQ-011 index_data  in  WORD_W  operand value read for an INDEX, sampled with the INDEX word.
REQ-012 out_valid  out  1  decoded target word available.
REQ-013 out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-014 out_instr  out  WORD_W  effective instruction (raw + accumulated index).
REQ-015 out_extended  out  1  target follows an EXTEND prefix.
REQ-016 out_indexed  out  1  target follows at least one INDEX.
REQ-017 out_suppress  out  1  target is an opcode-0 transfer inside the reset hold window.
REQ-018 int_inhibit  out  1  high while any prefix is pending.
REQ-019 chain_err  out  1  one-cycle pulse on INDEX depth overflow.

Function
REQ-020 Effective word eff = instr + idx_acc, modulo 2^WORD_W; all classification SHALL use eff.
REQ-021 EXTEND: not extended, eff opcode 0, address 0o0006.
REQ-022 INDEX: not extended, opcode 5 with bits[11:10]=00; or extended, opcode 5 any address.
REQ-023 All other words are targets.
REQ-024 Prefix accept: no output; EXTEND sets ext_pend; INDEX sets idx_acc <= idx_acc + index_data (mod 2^WORD_W), increments depth, and keeps ext_pend if the INDEX was extended, else clears it.
REQ-025 Target accept: out_instr <= eff, out_extended <= ext_pend, out_indexed <= (depth != 0), out_valid <= 1 next cycle; ext_pend, idx_acc and depth then clear. Latency one cycle.
REQ-026 in_ready = !out_valid | out_ready (single output entry, full throughput); prefixes SHALL be accepted under the same rule.
REQ-027 While out_valid & !out_ready, all outputs SHALL hold stable.
REQ-028 State encoding SHALL be BASE (nothing pending), EXT (ext_pend only), IDX (depth>0, no extend), IDX_EXT (depth>0, ext_pend); transitions only on accepted words, flush or reset.
REQ-029 An INDEX accepted when depth == MAX_INDEX_DEPTH SHALL pulse chain_err, clear all pending state to BASE, and emit nothing.
REQ-030 EXTEND accepted in EXT or IDX_EXT SHALL be idempotent (remains extended).
REQ-031 int_inhibit = (state != BASE), combinational from registered state.
REQ-032 Hold counter loads RESET_HOLD at reset, decrements to 0 each cycle; out_suppress <= 1 for a target of opcode 0, not extended, address not 0o0002 or 0o0006, accepted while counter != 0.
REQ-033 flush SHALL take priority over same-cycle accept and output handshake: next cycle state BASE, idx_acc 0, depth 0, out_valid 0; input in that cycle is dropped; hold counter unaffected.

Reset
REQ-034 On rst_l=0 at a clock edge: out_valid, out_extended, out_indexed, out_suppress, chain_err, int_inhibit 0; out_instr 0; state BASE; idx_acc 0; depth 0; hold counter RESET_HOLD.
REQ-035 Reset mid-chain or mid-stall SHALL discard all pending prefixes and the output entry with no out_valid pulse.
REQ-036 in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-037 EXTEND 0o00006 then 0o70100 -> one output, out_instr 0o70100, out_extended 1, out_indexed 0; int_inhibit 1 for exactly one cycle.
REQ-038 INDEX 0o50100 with index_data 0o00003, then 0o30200 -> out_instr 0o30203, out_indexed 1, out_extended 0.
REQ-039 Default depth 1: INDEX, INDEX, 0o30200 -> chain_err pulse on second INDEX, output 0o30200 with out_indexed 0.
REQ-040 Target held with out_ready 0 for 3 cycles -> out_valid/out_instr stable, in_ready 0; out_ready 1 -> accept, next word follows without a bubble.
REQ-041 EXTEND then flush with a target in the same cycle -> no output, state BASE, int_inhibit 0.
REQ-042 RESET_HOLD=2, 0o00100 presented on first cycle after reset -> out_suppress 1; same word after counter expiry -> out_suppress 0.

Source files
------------

// File: rtl/decode_prefix_seq.sv
// decode_prefix_seq: folds EXTEND/INDEX prefixes into the following target word through a single output entry
module decode_prefix_seq #(
  parameter int WORD_W          = 15,
  parameter int MAX_INDEX_DEPTH = 1,
  parameter int RESET_HOLD      = 1
) (
  input  logic              clock,
  input  logic              rst_l,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] index_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic              out_extended,
  output logic              out_indexed,
  output logic              out_suppress,
  output logic              int_inhibit,
  output logic              chain_err
);
  typedef enum logic [1:0] {BASE, EXT, IDX, IDX_EXT} state_t;
  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_acc, r_out_instr, w_eff;
  logic [2:0]        r_depth;
  logic [3:0]        r_hold;
  logic              r_out_valid, r_out_ext, r_out_idx, r_out_sup, r_chain_err;
  logic [2:0]        w_op;
  logic [11:0]       w_addr;
  logic              w_ext_pend, w_is_ext, w_is_idx, w_acc, w_tgt, w_ovf, w_hold_nz, w_sup;
  // All classification is done on the word after the accumulated index offset.
  assign w_eff      = instr + r_acc;
  assign w_op       = w_eff[14:12];
  assign w_addr     = w_eff[11:0];
  assign w_ext_pend = (r_state == EXT) || (r_state == IDX_EXT);
  assign w_is_ext   = !w_ext_pend && w_op == 3'd0 && w_addr == 12'o0006;
  assign w_is_idx   = w_op == 3'd5 && (w_ext_pend || w_addr[11:10] == 2'b00);
  assign in_ready   = !r_out_valid || out_ready;
  assign w_acc      = in_valid && in_ready && !flush;
  assign w_tgt      = w_acc && !w_is_ext && !w_is_idx;
  assign w_ovf      = w_acc && w_is_idx && r_depth == 3'(MAX_INDEX_DEPTH);
  assign w_hold_nz  = r_hold != 4'd0;
  assign w_sup      = w_op == 3'd0 && !w_ext_pend && w_addr != 12'o0002 && w_addr != 12'o0006 && w_hold_nz;
  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = BASE;
    else if (w_acc)
      w_state_nxt = w_is_ext ? ((r_state == IDX) ? IDX_EXT : EXT) :
                    w_is_idx ? (w_ovf ? BASE : (w_ext_pend ? IDX_EXT : IDX)) : BASE;
  end
  always_ff @(posedge clock) begin
    if (!rst_l) begin
      r_state     <= BASE;
      r_acc       <= '0;
      r_depth     <= '0;
      r_hold      <= 4'(RESET_HOLD);
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_ext   <= 1'b0;
      r_out_idx   <= 1'b0;
      r_out_sup   <= 1'b0;
      r_chain_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nz ? r_hold - 4'd1 : r_hold;
      r_chain_err <= w_ovf;
      r_out_valid <= !flush && (w_tgt || (r_out_valid && !out_ready));
      if (flush || w_tgt || w_ovf) begin
        r_acc   <= '0;
        r_depth <= '0;
      end else if (w_acc && w_is_idx) begin
        r_acc   <= r_acc + index_data;
        r_depth <= r_depth + 3'd1;
      end
      if (w_tgt) begin
        r_out_instr <= w_eff;
        r_out_ext   <= w_ext_pend;
        r_out_idx   <= r_depth != 3'd0;
        r_out_sup   <= w_sup;
      end
    end
  end
  assign out_valid    = r_out_valid;
  assign out_instr    = r_out_instr;
  assign out_extended = r_out_ext;
  assign out_indexed  = r_out_idx;
  assign out_suppress = r_out_sup;
  assign chain_err    = r_chain_err;
  assign int_inhibit  = r_state != BASE;
endmodule
